// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one radix-2 shift-add / restoring-subtract
// step per cycle, fixed latency, start/busy/done handshake.
module muldiv_unit #(
  parameter int data_width = 32,
  parameter int sel_width  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [data_width-1:0] operand1,
  input  logic [data_width-1:0] operand2,
  input  logic [sel_width-1:0]  opSel,
  output logic                  busy,
  output logic                  done,
  output logic [data_width-1:0] result,
  output logic                  zero
);

  localparam int W  = data_width;
  localparam int CW = $clog2(data_width);

  localparam logic [sel_width-1:0] OP_MUL   = sel_width'(0);
  localparam logic [sel_width-1:0] OP_MULH  = sel_width'(1);
  localparam logic [sel_width-1:0] OP_MULHU = sel_width'(2);
  localparam logic [sel_width-1:0] OP_DIV   = sel_width'(3);
  localparam logic [sel_width-1:0] OP_DIVU  = sel_width'(4);
  localparam logic [sel_width-1:0] OP_REM   = sel_width'(5);
  localparam logic [sel_width-1:0] OP_REMU  = sel_width'(6);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        count_q, count_d;
  logic [sel_width-1:0] op_q, op_d;
  logic [2*W-1:0]       acc_q, acc_d;      // product, or {unused, dividend/quotient shifter}
  logic [W:0]           rem_q, rem_d;      // partial remainder
  logic [W-1:0]         opnd_q, opnd_d;    // multiplicand or divisor magnitude
  logic [W-1:0]         op1_q, op1_d;
  logic                 sign1_q, sign1_d;
  logic                 sign2_q, sign2_d;
  logic                 div0_q, div0_d;
  logic [W-1:0]         result_q, result_d;
  logic                 done_q, done_d;

  // Accept-time operand conditioning.
  logic         is_signed_in, is_div_in, neg1_in, neg2_in;
  logic [W-1:0] mag1_in, mag2_in;

  assign is_signed_in = (opSel == OP_MULH) || (opSel == OP_DIV) || (opSel == OP_REM);
  assign is_div_in    = (opSel == OP_DIV) || (opSel == OP_DIVU) ||
                        (opSel == OP_REM) || (opSel == OP_REMU);
  assign neg1_in      = is_signed_in & operand1[W-1];
  assign neg2_in      = is_signed_in & operand2[W-1];
  assign mag1_in      = neg1_in ? -operand1 : operand1;
  assign mag2_in      = neg2_in ? -operand2 : operand2;

  // Per-iteration datapath.
  logic         is_div_q;
  logic [W:0]   mul_sum;
  logic [W:0]   div_shift;
  logic [W+1:0] div_diff;
  logic         div_ok;

  assign is_div_q  = (op_q == OP_DIV) || (op_q == OP_DIVU) ||
                     (op_q == OP_REM) || (op_q == OP_REMU);
  assign mul_sum   = {1'b0, acc_q[2*W-1:W]} + {1'b0, (acc_q[0] ? opnd_q : {W{1'b0}})};
  assign div_shift = {rem_q[W-1:0], acc_q[W-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
  assign div_ok    = ~div_diff[W+1];

  // Sign fix-up and special-case selection on the final accumulator state.
  logic [2*W-1:0] prod_neg;
  logic [W-1:0]   quot, remd, final_res;

  assign prod_neg = -acc_q;
  assign quot     = acc_q[W-1:0];
  assign remd     = rem_q[W-1:0];

  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    final_res = {W{1'b1}};
    case (op_q)
      OP_MUL:   final_res = acc_q[W-1:0];
      OP_MULH:  final_res = (sign1_q ^ sign2_q) ? prod_neg[2*W-1:W] : acc_q[2*W-1:W];
      OP_MULHU: final_res = acc_q[2*W-1:W];
      OP_DIV:   final_res = div0_q ? {W{1'b1}} : ((sign1_q ^ sign2_q) ? -quot : quot);
      OP_DIVU:  final_res = quot;
      OP_REM:   final_res = div0_q ? op1_q : (sign1_q ? -remd : remd);
      OP_REMU:  final_res = remd;
      default:  final_res = {W{1'b1}};
    endcase
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    op_d     = op_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    opnd_d   = opnd_q;
    op1_d    = op1_q;
    sign1_d  = sign1_q;
    sign2_d  = sign2_q;
    div0_d   = div0_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = opSel;
          count_d = '0;
          sign1_d = neg1_in;
          sign2_d = neg2_in;
          div0_d  = (operand2 == '0);
          op1_d   = operand1;
          rem_d   = '0;
          acc_d   = {{W{1'b0}}, (is_div_in ? mag1_in : mag2_in)};
          opnd_d  = is_div_in ? mag2_in : mag1_in;
          state_d = CALC;
        end
      end
      CALC: begin
        if (is_div_q) begin
          rem_d = div_ok ? div_diff[W:0] : div_shift;
          acc_d = {acc_q[2*W-1:W], acc_q[W-2:0], div_ok};
        end else begin
          acc_d = {mul_sum, acc_q[W-1:1]};
        end
        if (count_q == CW'(W-1)) state_d = DONE;
        else                     count_d = count_q + 1'b1;
      end
      DONE: begin
        result_d = final_res;
        done_d   = 1'b1;
        count_d  = '0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      opnd_q   <= '0;
      op1_q    <= '0;
      sign1_q  <= 1'b0;
      sign2_q  <= 1'b0;
      div0_q   <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      op_q     <= op_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      opnd_q   <= opnd_d;
      op1_q    <= op1_d;
      sign1_q  <= sign1_d;
      sign2_q  <= sign2_d;
      div0_q   <= div0_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign result = result_q;
  assign zero   = (result_q == '0);

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed RV32M vectors, handshake and reset scenarios,
// and random operations checked against a plain-arithmetic reference model.
module tb_muldiv_unit;

  logic        clk, rst, start;
  logic [31:0] operand1, operand2;
  logic [2:0]  opSel;
  logic        busy, done, zero;
  logic [31:0] result;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int LAT = 33;

  muldiv_unit #(.data_width(32), .sel_width(3)) dut (
    .clk(clk), .rst(rst), .start(start),
    .operand1(operand1), .operand2(operand2), .opSel(opSel),
    .busy(busy), .done(done), .result(result), .zero(zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  // Reference model straight from the RV32M definitions using 64-bit integer arithmetic.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd3: begin if (b == 0) return 32'hFFFF_FFFF; p = 64'(sa / sb); return p[31:0]; end
      3'd4: begin if (b == 0) return 32'hFFFF_FFFF; return a / b; end
      3'd5: begin if (b == 0) return a; p = 64'(sa % sb); return p[31:0]; end
      3'd6: begin if (b == 0) return a; return a % b; end
      default: return 32'hFFFF_FFFF;
    endcase
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 200));
      default: return $urandom;
    endcase
  endfunction

  // Call at #1 after an edge with busy low; returns at #1 after the accepting edge (k=0).
  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    opSel    = op;
    operand1 = a;
    operand2 = b;
    start    = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    operand1 = $urandom;
    operand2 = $urandom;
    opSel    = 3'($urandom_range(0, 7));
  endtask

  // Waits (bounded) for done; lat is cycles after the accepting edge, -1 on timeout.
  task automatic wait_done(input int k0, output logic [31:0] res, output logic z,
                           output int lat, output int bcnt, output logic busy_at_done);
    lat = -1; bcnt = 0; res = '0; z = 1'b0; busy_at_done = 1'b1;
    for (int k = k0; k <= 60; k++) begin
      if (done === 1'b1) begin
        lat = k; res = result; z = zero; busy_at_done = busy;
        break;
      end
      if (busy === 1'b1) bcnt++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; operand1 = '0; operand2 = '0; opSel = '0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (done !== 1'b0)   begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
    n_checks++; if (result !== 32'h0) begin n_fail++; $display("FAIL reset_result: got %h want 0", result); end
    n_checks++; if (zero !== 1'b1)   begin n_fail++; $display("FAIL reset_zero: got %b want 1", zero); end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    vec_t v[16];
    logic [31:0] res; logic z, bad; int lat, bcnt;
    v[0]  = '{3'd0, 32'd7,         32'd6,         32'd42};
    v[1]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    v[2]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    v[3]  = '{3'd0, 32'h8000_0000, 32'd2,         32'h0000_0000};
    v[4]  = '{3'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
    v[5]  = '{3'd5, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
    v[6]  = '{3'd4, 32'd100,       32'd7,         32'd14};
    v[7]  = '{3'd6, 32'd100,       32'd7,         32'd2};
    v[8]  = '{3'd3, 32'd5,         32'd0,         32'hFFFF_FFFF};
    v[9]  = '{3'd6, 32'd5,         32'd0,         32'd5};
    v[10] = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    v[11] = '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    v[12] = '{3'd7, 32'h1234_5678, 32'd9,         32'hFFFF_FFFF};
    v[13] = '{3'd3, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF};
    v[14] = '{3'd5, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB};
    v[15] = '{3'd1, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF};
    for (int i = 0; i < 16; i++) begin
      launch(v[i].op, v[i].a, v[i].b);
      wait_done(0, res, z, lat, bcnt, bad);
      n_checks++; if (res !== v[i].exp) begin n_fail++;
        $display("FAIL directed_result[%0d] op=%0d a=%h b=%h: got %h want %h", i, v[i].op, v[i].a, v[i].b, res, v[i].exp); end
      n_checks++; if (z !== (v[i].exp == 0)) begin n_fail++;
        $display("FAIL directed_zero[%0d]: got %b want %b", i, z, (v[i].exp == 0)); end
      n_checks++; if (lat !== LAT) begin n_fail++;
        $display("FAIL directed_latency[%0d]: got %0d want %0d", i, lat, LAT); end
      n_checks++; if (bcnt !== LAT || bad !== 1'b0) begin n_fail++;
        $display("FAIL directed_busy[%0d]: busy cycles %0d want %0d, busy at done %b want 0", i, bcnt, LAT, bad); end
      @(posedge clk); #1;
      n_checks++; if (done !== 1'b0 || result !== v[i].exp) begin n_fail++;
        $display("FAIL directed_hold[%0d]: done %b want 0, result %h want %h", i, done, result, v[i].exp); end
    end
  endtask

  task automatic test_random();
    logic [2:0] op; logic [31:0] a, b, exp, res; logic z, bad; int lat, bcnt;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      a  = pick_operand();
      b  = pick_operand();
      exp = model(op, a, b);
      launch(op, a, b);
      wait_done(0, res, z, lat, bcnt, bad);
      n_checks++; if (res !== exp || z !== (exp == 0) || lat !== LAT) begin n_fail++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h z=%b lat=%0d want %h z=%b lat=%0d",
                 i, op, a, b, res, z, lat, exp, (exp == 0), LAT); end
    end
  endtask

  task automatic test_ignore_start();
    logic [31:0] res; logic z, bad; int lat, bcnt; int extra;
    launch(3'd4, 32'd100, 32'd7);
    repeat (5) begin @(posedge clk); #1; end
    opSel = 3'd0; operand1 = 32'd3; operand2 = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(6, res, z, lat, bcnt, bad);
    n_checks++; if (res !== 32'd14 || lat !== LAT) begin n_fail++;
      $display("FAIL ignore_start: result %h lat %0d, want %h lat %0d", res, lat, 32'd14, LAT); end
    extra = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    n_checks++; if (extra !== 0) begin n_fail++;
      $display("FAIL ignore_no_queue: %0d busy/done cycles after op, want 0", extra); end
    n_checks++; if (result !== 32'd14) begin n_fail++;
      $display("FAIL ignore_hold: result %h want %h", result, 32'd14); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] op[3]; logic [31:0] a[3], b[3];
    logic [31:0] res; logic z, bad; int lat, bcnt;
    op[0] = 3'd0; a[0] = 32'd1000;      b[0] = 32'd1000;
    op[1] = 3'd3; a[1] = 32'hFFFF_FC18; b[1] = 32'd7;
    op[2] = 3'd2; a[2] = 32'h8000_0001; b[2] = 32'h0000_0004;
    launch(op[0], a[0], b[0]);
    for (int i = 0; i < 3; i++) begin
      wait_done(0, res, z, lat, bcnt, bad);
      n_checks++; if (res !== model(op[i], a[i], b[i]) || lat !== LAT) begin n_fail++;
        $display("FAIL back_to_back[%0d]: result %h lat %0d, want %h lat %0d", i, res, lat, model(op[i], a[i], b[i]), LAT); end
      if (i < 2) launch(op[i+1], a[i+1], b[i+1]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_abort();
    logic [31:0] res; logic z, bad; int lat, bcnt; int seen;
    launch(3'd4, 32'd1000, 32'd3);
    wait_done(0, res, z, lat, bcnt, bad);
    n_checks++; if (res !== 32'd333) begin n_fail++;
      $display("FAIL abort_setup: result %h want %h", res, 32'd333); end
    @(posedge clk); #1;
    launch(3'd4, 32'hFFFF_FFFF, 32'd3);
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (busy !== 1'b0 || result !== 32'h0 || zero !== 1'b1 || done !== 1'b0) begin n_fail++;
      $display("FAIL abort_state: busy %b result %h zero %b done %b, want 0 0 1 0", busy, result, zero, done); end
    rst = 1'b1;
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    n_checks++; if (seen !== 0) begin n_fail++;
      $display("FAIL abort_no_done: %0d done pulses, want 0", seen); end
    launch(3'd0, 32'd3, 32'd5);
    wait_done(0, res, z, lat, bcnt, bad);
    n_checks++; if (res !== 32'd15 || lat !== LAT) begin n_fail++;
      $display("FAIL abort_recover: result %h lat %0d, want %h lat %0d", res, lat, 32'd15, LAT); end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignore_start();
    test_back_to_back();
    test_reset_abort();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
